// File: rtl/pipeline_ctrl_pkg.sv
// Shared pipeline-control constants: stall bit indices, stall-vector encodings,
// FSM state encoding and a saturating-increment helper.
package pipeline_ctrl_pkg;

  localparam int STALL_W = 6;
  localparam int ADDR_W  = 32;

  localparam int STALL_PC  = 0;
  localparam int STALL_IF  = 1;
  localparam int STALL_ID  = 2;
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;

  localparam logic Stall   = 1'b1;
  localparam logic NoStall = 1'b0;
  localparam logic Jump    = 1'b1;
  localparam logic NoJump  = 1'b0;

  localparam logic [STALL_W-1:0] STALL_VEC_MEM  = 6'b011111;
  localparam logic [STALL_W-1:0] STALL_VEC_ID   = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_VEC_IF   = 6'b000011;
  localparam logic [STALL_W-1:0] STALL_VEC_NONE = 6'b000000;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } ctrl_state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_stall_arbiter.sv
// Priority encoder for the base stall vector: MEM over ID over IF.
// Purely combinational, zero latency; no handshake of its own.
module stall_arbiter
  import pipeline_ctrl_pkg::*;
(
  input  logic               stall_req_if,
  input  logic               stall_req_id,
  input  logic               stall_req_mem,
  output logic [STALL_W-1:0] base_stall
);

  always_comb begin
    base_stall = STALL_VEC_NONE;
    if (stall_req_mem == Stall) begin
      base_stall = STALL_VEC_MEM;
    end else if (stall_req_id == Stall) begin
      base_stall = STALL_VEC_ID;
    end else if (stall_req_if == Stall) begin
      base_stall = STALL_VEC_IF;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush control; stall, flush and idle redirects are combinational,
// a redirect arriving during an in-flight fetch is parked until IF releases; rdy_in=0 freezes state.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
(
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               stallReqIF_in,
  input  logic               stallReqID_in,
  input  logic               stallReqMEM_in,
  input  logic               jumpReq_in,
  input  logic [ADDR_W-1:0]  jumpTarget_in,
  output logic [STALL_W-1:0] stall_out,
  output logic               pcJump_out,
  output logic               redirect_out,
  output logic [ADDR_W-1:0]  redirectPc_out,
  output logic               discardFetch_out,
  output logic [31:0]        stallCycles_out,
  output logic [31:0]        flushCount_out
);

  ctrl_state_e       state_q, state_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic [31:0]       stall_cnt_q, stall_cnt_d;
  logic [31:0]       flush_cnt_q, flush_cnt_d;
  logic [STALL_W-1:0] base_stall;
  logic              accept;

  stall_arbiter u_stall_arbiter (
    .stall_req_if  (stallReqIF_in),
    .stall_req_id  (stallReqID_in),
    .stall_req_mem (stallReqMEM_in),
    .base_stall    (base_stall)
  );

  // While a redirect is parked, PC and IF must not advance past the stale fetch.
  always_comb begin
    stall_out = base_stall;
    if (state_q == ST_PENDING) begin
      stall_out[STALL_PC] = Stall;
      stall_out[STALL_IF] = Stall;
    end
  end

  assign accept     = jumpReq_in & ~stall_out[STALL_EX] & rdy_in;
  assign pcJump_out = accept ? Jump : NoJump;

  always_comb begin
    state_d          = state_q;
    tgt_d            = tgt_q;
    redirect_out     = 1'b0;
    redirectPc_out   = '0;
    discardFetch_out = (state_q == ST_PENDING);
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (!stallReqIF_in) begin
            redirect_out   = 1'b1;
            redirectPc_out = jumpTarget_in;
          end else begin
            tgt_d   = jumpTarget_in;
            state_d = ST_PENDING;
          end
        end
      end
      ST_PENDING: begin
        if (accept) begin
          tgt_d = jumpTarget_in;
        end
        // A jump accepted on the release cycle is newer than the parked target.
        if (rdy_in && !stallReqIF_in) begin
          redirect_out   = 1'b1;
          redirectPc_out = accept ? jumpTarget_in : tgt_q;
          state_d        = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (rdy_in && (|stall_out)) begin
      stall_cnt_d = sat_inc(stall_cnt_q);
    end
    if (accept) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= ST_IDLE;
      tgt_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (rdy_in) begin
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stallCycles_out = stall_cnt_q;
  assign flushCount_out  = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed scenarios plus a randomized run against a behavioural model of the controller.
module tb_pipeline_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        stallReqIF_in = 1'b0;
  logic        stallReqID_in = 1'b0;
  logic        stallReqMEM_in = 1'b0;
  logic        jumpReq_in = 1'b0;
  logic [31:0] jumpTarget_in = '0;
  logic [5:0]  stall_out;
  logic        pcJump_out;
  logic        redirect_out;
  logic [31:0] redirectPc_out;
  logic        discardFetch_out;
  logic [31:0] stallCycles_out;
  logic [31:0] flushCount_out;

  int checks = 0;
  int failures = 0;

  always #5 clk_in = ~clk_in;

  pipeline_ctrl dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .rdy_in           (rdy_in),
    .stallReqIF_in    (stallReqIF_in),
    .stallReqID_in    (stallReqID_in),
    .stallReqMEM_in   (stallReqMEM_in),
    .jumpReq_in       (jumpReq_in),
    .jumpTarget_in    (jumpTarget_in),
    .stall_out        (stall_out),
    .pcJump_out       (pcJump_out),
    .redirect_out     (redirect_out),
    .redirectPc_out   (redirectPc_out),
    .discardFetch_out (discardFetch_out),
    .stallCycles_out  (stallCycles_out),
    .flushCount_out   (flushCount_out)
  );

  task automatic drive(input logic rdy, input logic ifr, input logic idr, input logic memr,
                       input logic jr, input logic [31:0] tgt);
    rdy_in = rdy; stallReqIF_in = ifr; stallReqID_in = idr; stallReqMEM_in = memr;
    jumpReq_in = jr; jumpTarget_in = tgt;
  endtask

  task automatic to_neg();
    @(negedge clk_in);
  endtask

  task automatic to_pos();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0, 0, 0);
    rst_in = 1'b1;
    to_pos();
    rst_in = 1'b0;
    to_neg();
    checks++; if (stall_out !== 6'b0) begin failures++; $display("FAIL reset_stall got=%b exp=%b", stall_out, 6'b0); end
    checks++; if (pcJump_out !== 1'b0) begin failures++; $display("FAIL reset_pcjump got=%b exp=0", pcJump_out); end
    checks++; if (redirect_out !== 1'b0 || redirectPc_out !== 32'h0) begin failures++; $display("FAIL reset_redirect got=%b/%h exp=0/0", redirect_out, redirectPc_out); end
    checks++; if (discardFetch_out !== 1'b0) begin failures++; $display("FAIL reset_discard got=%b exp=0", discardFetch_out); end
    checks++; if (stallCycles_out !== 32'h0 || flushCount_out !== 32'h0) begin failures++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", stallCycles_out, flushCount_out); end
  endtask

  task automatic test_mem_stall();
    logic [31:0] c0, f0;
    drive(1, 0, 0, 1, 0, 0);
    to_neg();
    checks++; if (stall_out !== 6'b011111) begin failures++; $display("FAIL mem_stall_vec got=%b exp=%b", stall_out, 6'b011111); end
    c0 = stallCycles_out;
    f0 = flushCount_out;
    for (int i = 1; i <= 3; i++) begin
      to_pos();
      checks++; if (stallCycles_out !== c0 + i) begin failures++; $display("FAIL mem_stall_cnt got=%0d exp=%0d", stallCycles_out, c0 + i); end
    end
    drive(1, 0, 0, 0, 0, 0);
    to_pos();
    checks++; if (stallCycles_out !== c0 + 3) begin failures++; $display("FAIL mem_stall_cnt_idle got=%0d exp=%0d", stallCycles_out, c0 + 3); end
    checks++; if (flushCount_out !== f0) begin failures++; $display("FAIL mem_stall_flush got=%0d exp=%0d", flushCount_out, f0); end
  endtask

  task automatic test_jump_idle();
    logic [31:0] f0;
    f0 = flushCount_out;
    drive(1, 0, 0, 0, 1, 32'h0000_1000);
    to_neg();
    checks++; if (pcJump_out !== 1'b1) begin failures++; $display("FAIL jidle_pcjump got=%b exp=1", pcJump_out); end
    checks++; if (redirect_out !== 1'b1 || redirectPc_out !== 32'h1000) begin failures++; $display("FAIL jidle_redirect got=%b/%h exp=1/1000", redirect_out, redirectPc_out); end
    checks++; if (discardFetch_out !== 1'b0 || stall_out !== 6'b0) begin failures++; $display("FAIL jidle_quiet got=%b/%b exp=0/000000", discardFetch_out, stall_out); end
    to_pos();
    drive(1, 0, 0, 0, 0, 0);
    checks++; if (flushCount_out !== f0 + 1) begin failures++; $display("FAIL jidle_flushcnt got=%0d exp=%0d", flushCount_out, f0 + 1); end
  endtask

  task automatic test_jump_pending();
    logic [31:0] f0;
    int pulses;
    f0 = flushCount_out;
    pulses = 0;
    drive(1, 1, 0, 0, 1, 32'h0000_2000);
    to_neg();
    if (pcJump_out === 1'b1) pulses++;
    checks++; if (redirect_out !== 1'b0 || redirectPc_out !== 32'h0) begin failures++; $display("FAIL jpend_no_redirect got=%b/%h exp=0/0", redirect_out, redirectPc_out); end
    to_pos();
    drive(1, 1, 0, 0, 0, 32'h0000_dead);
    for (int i = 0; i < 3; i++) begin
      to_neg();
      if (pcJump_out === 1'b1) pulses++;
      checks++; if (discardFetch_out !== 1'b1 || stall_out[1:0] !== 2'b11) begin failures++; $display("FAIL jpend_hold got=%b/%b exp=1/11", discardFetch_out, stall_out[1:0]); end
      checks++; if (redirect_out !== 1'b0) begin failures++; $display("FAIL jpend_hold_redirect got=%b exp=0", redirect_out); end
      to_pos();
    end
    drive(1, 0, 0, 0, 0, 32'h0000_dead);
    to_neg();
    if (pcJump_out === 1'b1) pulses++;
    checks++; if (redirect_out !== 1'b1 || redirectPc_out !== 32'h2000) begin failures++; $display("FAIL jpend_release got=%b/%h exp=1/2000", redirect_out, redirectPc_out); end
    checks++; if (stall_out !== 6'b000011 || discardFetch_out !== 1'b1) begin failures++; $display("FAIL jpend_release_stall got=%b/%b exp=000011/1", stall_out, discardFetch_out); end
    to_pos();
    to_neg();
    checks++; if (discardFetch_out !== 1'b0 || redirect_out !== 1'b0 || stall_out !== 6'b0) begin failures++; $display("FAIL jpend_idle_after got=%b/%b/%b exp=0/0/000000", discardFetch_out, redirect_out, stall_out); end
    checks++; if (pulses != 1 || flushCount_out !== f0 + 1) begin failures++; $display("FAIL jpend_one_pulse got=%0d/%0d exp=1/%0d", pulses, flushCount_out, f0 + 1); end
  endtask

  task automatic test_held_jump();
    logic [31:0] f0;
    int accepts;
    f0 = flushCount_out;
    accepts = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, (i < 3), 1, 32'h0000_4000);
      to_neg();
      if (pcJump_out === 1'b1) accepts++;
      if (i == 3) begin
        checks++; if (pcJump_out !== 1'b1 || redirect_out !== 1'b1 || redirectPc_out !== 32'h4000) begin failures++; $display("FAIL held_accept got=%b/%b/%h exp=1/1/4000", pcJump_out, redirect_out, redirectPc_out); end
      end else begin
        checks++; if (pcJump_out !== 1'b0 || redirect_out !== 1'b0) begin failures++; $display("FAIL held_blocked got=%b/%b exp=0/0", pcJump_out, redirect_out); end
      end
      to_pos();
    end
    drive(1, 0, 0, 0, 0, 0);
    checks++; if (accepts != 1 || flushCount_out !== f0 + 1) begin failures++; $display("FAIL held_count got=%0d/%0d exp=1/%0d", accepts, flushCount_out, f0 + 1); end
  endtask

  task automatic test_reset_pending();
    drive(1, 1, 0, 0, 1, 32'h0000_3000);
    to_pos();
    drive(1, 1, 0, 0, 0, 0);
    to_neg();
    checks++; if (discardFetch_out !== 1'b1) begin failures++; $display("FAIL rstpend_entered got=%b exp=1", discardFetch_out); end
    rst_in = 1'b1;
    to_pos();
    rst_in = 1'b0;
    checks++; if (stallCycles_out !== 32'h0 || flushCount_out !== 32'h0) begin failures++; $display("FAIL rstpend_counters got=%0d/%0d exp=0/0", stallCycles_out, flushCount_out); end
    to_neg();
    checks++; if (discardFetch_out !== 1'b0) begin failures++; $display("FAIL rstpend_discard got=%b exp=0", discardFetch_out); end
    to_pos();
    drive(1, 0, 0, 0, 0, 0);
    to_neg();
    checks++; if (redirect_out !== 1'b0 || redirectPc_out !== 32'h0 || stall_out !== 6'b0) begin failures++; $display("FAIL rstpend_no_redirect got=%b/%h/%b exp=0/0/000000", redirect_out, redirectPc_out, stall_out); end
  endtask

  task automatic test_rdy_freeze();
    logic [31:0] s0, f0;
    drive(0, 0, 1, 0, 1, 32'h0000_5000);
    to_neg();
    checks++; if (pcJump_out !== 1'b0 || redirect_out !== 1'b0 || redirectPc_out !== 32'h0) begin failures++; $display("FAIL rdy_blocked got=%b/%b/%h exp=0/0/0", pcJump_out, redirect_out, redirectPc_out); end
    checks++; if (stall_out !== 6'b000111) begin failures++; $display("FAIL rdy_stall_driven got=%b exp=000111", stall_out); end
    s0 = stallCycles_out;
    f0 = flushCount_out;
    to_pos();
    to_pos();
    checks++; if (stallCycles_out !== s0 || flushCount_out !== f0) begin failures++; $display("FAIL rdy_frozen got=%0d/%0d exp=%0d/%0d", stallCycles_out, flushCount_out, s0, f0); end
    rdy_in = 1'b1;
    to_neg();
    checks++; if (pcJump_out !== 1'b1 || redirect_out !== 1'b1 || redirectPc_out !== 32'h5000) begin failures++; $display("FAIL rdy_resume got=%b/%b/%h exp=1/1/5000", pcJump_out, redirect_out, redirectPc_out); end
    to_pos();
    drive(1, 0, 0, 0, 0, 0);
    checks++; if (stallCycles_out !== s0 + 1 || flushCount_out !== f0 + 1) begin failures++; $display("FAIL rdy_resume_cnt got=%0d/%0d exp=%0d/%0d", stallCycles_out, flushCount_out, s0 + 1, f0 + 1); end
  endtask

  // Model state: is a redirect parked, what target, and the two counters.
  task automatic test_random();
    bit          m_pend;
    logic [31:0] m_tgt, m_scnt, m_fcnt;
    logic [5:0]  e_stall;
    logic        e_acc, e_redir;
    logic [31:0] e_pc;
    int          bad;
    bad = 0;
    drive(1, 0, 0, 0, 0, 0);
    rst_in = 1'b1;
    to_pos();
    rst_in = 1'b0;
    m_pend = 0; m_tgt = '0; m_scnt = '0; m_fcnt = '0;
    for (int n = 0; n < 600; n++) begin
      drive(($urandom_range(0, 7) != 0), ($urandom_range(0, 2) == 0), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0), $urandom() & 32'hFFFF_FFFC);
      rst_in = ($urandom_range(0, 99) == 0);
      to_neg();
      if (stallReqMEM_in) e_stall = 6'b011111;
      else if (stallReqID_in) e_stall = 6'b000111;
      else if (stallReqIF_in) e_stall = 6'b000011;
      else e_stall = 6'b000000;
      if (m_pend) e_stall = e_stall | 6'b000011;
      e_acc   = jumpReq_in && !stallReqMEM_in && rdy_in;
      e_redir = rdy_in && !stallReqIF_in && (m_pend || e_acc);
      e_pc    = !e_redir ? 32'h0 : (e_acc ? jumpTarget_in : m_tgt);
      checks++;
      if (stall_out !== e_stall || pcJump_out !== e_acc || redirect_out !== e_redir ||
          redirectPc_out !== e_pc || discardFetch_out !== m_pend) begin
        failures++;
        bad++;
        if (bad <= 5) $display("FAIL rand_comb cyc=%0d got=%b/%b/%b/%h/%b exp=%b/%b/%b/%h/%b", n,
          stall_out, pcJump_out, redirect_out, redirectPc_out, discardFetch_out,
          e_stall, e_acc, e_redir, e_pc, m_pend);
      end
      if (rst_in) begin
        m_pend = 0; m_tgt = '0; m_scnt = '0; m_fcnt = '0;
      end else if (rdy_in) begin
        if (e_acc && stallReqIF_in) begin
          m_pend = 1; m_tgt = jumpTarget_in;
        end else if (m_pend && !stallReqIF_in) begin
          m_pend = 0;
        end
        if (e_stall != 0 && m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 1;
        if (e_acc) m_fcnt = m_fcnt + 1;
      end
      to_pos();
      checks++;
      if (stallCycles_out !== m_scnt || flushCount_out !== m_fcnt) begin
        failures++;
        bad++;
        if (bad <= 5) $display("FAIL rand_cnt cyc=%0d got=%0d/%0d exp=%0d/%0d", n,
          stallCycles_out, flushCount_out, m_scnt, m_fcnt);
      end
    end
    rst_in = 1'b0;
    drive(1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_mem_stall();
    test_jump_idle();
    test_jump_pending();
    test_held_jump();
    test_reset_pending();
    test_rdy_freeze();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
